// File: rtl/l80_intctrl_pkg.sv
// l80_intctrl_pkg: shared definitions for the light8080 interrupt controller.
//   state_t      - handshake FSM states
//   REG_*        - register select codes seen through the SOC I/O decode
//   RST_TMPL     - RST opcode template (11 nnn 111)
//   rst_opcode() - build the RST opcode for a 3-bit restart number
package l80_intctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;

  localparam logic [7:0] RST_TMPL      = 8'hC7;
  localparam int         STAT_BUSY_BIT = 7;

  function automatic logic [7:0] rst_opcode(input logic [2:0] rst);
    return RST_TMPL | {2'b00, rst, 3'b000};
  endfunction

endpackage

// File: rtl/l80_prio_enc.sv
// l80_prio_enc: lowest-index-wins priority encoder.
//   req   in  N  request vector (bit 0 highest priority)
//   valid out 1  any request set
//   idx   out 3  index of lowest set bit (0 when none)
module l80_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/l80_intctrl.sv
// l80_intctrl: vectored interrupt controller for the light8080 SOC.
// Latches rising edges of up to eight sources as pending, arbitrates by fixed
// priority (source 0 highest) and runs the intr/inta handshake, presenting an
// RST opcode on int_vec while the handshake is in progress.
//   clock, reset        system clock, synchronous active-high reset
//   irq_src             raw interrupt requests (edge triggered)
//   reg_sel/wr/rd/din   register window: MASK (RW), PEND (R/W1C), STAT (R)
//   reg_dout            registered read data
//   cpu_intr/inta/inte  CPU interrupt handshake
//   int_vec             RST opcode while busy, else 8'h00
module l80_intctrl
  import l80_intctrl_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int BASE_RST = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [1:0]         reg_sel,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [7:0]         reg_din,
  output logic [7:0]         reg_dout,
  output logic               cpu_intr,
  input  logic               cpu_inta,
  input  logic               cpu_inte,
  output logic [7:0]         int_vec
);

  logic [NUM_SRC-1:0] irq_s, irq_d, irq_rise;
  logic [NUM_SRC-1:0] pend, mask, eligible, w1c, ack_clr;
  state_t             state;
  logic [2:0]         win_idx, stat_idx, elig_idx;
  logic               elig_vld;
  logic [7:0]         stat_word, rd_data;

  assign irq_rise = irq_s & ~irq_d;
  assign eligible = pend & mask;
  assign w1c      = (reg_wr && reg_sel == REG_PEND) ? reg_din[NUM_SRC-1:0] : '0;

  // Pending bit of the winner is cleared on the cycle inta is first seen.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      ack_clr[i] = (state == ST_REQ) && cpu_inta && (win_idx == 3'(i));
  end

  generate
    if (NUM_SRC < 8) begin : g_pad
      logic unused_din;
      assign unused_din = ^reg_din[7:NUM_SRC];
    end
  endgenerate

  l80_prio_enc #(.N(NUM_SRC)) u_prio (
    .req   (eligible),
    .valid (elig_vld),
    .idx   (elig_idx)
  );

  // Input sync, pending and mask. A new edge beats a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_s <= '0;
      irq_d <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      irq_s <= irq_src;
      irq_d <= irq_s;
      pend  <= (pend & ~w1c & ~ack_clr) | irq_rise;
      if (reg_wr && reg_sel == REG_MASK) mask <= reg_din[NUM_SRC-1:0];
    end
  end

  // Handshake FSM. win_idx is frozen for the whole REQ/ACK window.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cpu_intr <= 1'b0;
      win_idx  <= '0;
      stat_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: if (elig_vld && cpu_inte) begin
          state    <= ST_REQ;
          win_idx  <= elig_idx;
          cpu_intr <= 1'b1;
        end
        ST_REQ: if (cpu_inta) begin
          state    <= ST_ACK;
          stat_idx <= win_idx;
          cpu_intr <= 1'b0;
        end
        ST_ACK: if (!cpu_inta) state <= ST_IDLE;
        default: begin
          state    <= ST_IDLE;
          cpu_intr <= 1'b0;
        end
      endcase
    end
  end

  assign int_vec = (state != ST_IDLE) ? rst_opcode(3'(BASE_RST) + win_idx) : 8'h00;

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_BUSY_BIT] = (state != ST_IDLE);
    stat_word[2:0]           = stat_idx;
    case (reg_sel)
      REG_MASK: rd_data = 8'(mask);
      REG_PEND: rd_data = 8'(pend);
      REG_STAT: rd_data = stat_word;
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)       reg_dout <= 8'h00;
    else if (reg_rd) reg_dout <= rd_data;
  end

endmodule

// File: tb/tb_l80_intctrl.sv
module tb_l80_intctrl;
  import l80_intctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_src = '0;
  logic [1:0] reg_sel = '0;
  logic       reg_wr = 1'b0, reg_rd = 1'b0;
  logic [7:0] reg_din = '0;
  logic [7:0] reg_dout, int_vec;
  logic       cpu_intr;
  logic       cpu_inta = 1'b0, cpu_inte = 1'b1;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] vq[$];  // expected vectors, pushed when the source is raised
  logic [7:0] rq[$];  // expected read data, pushed when the read is issued

  l80_intctrl #(.NUM_SRC(4), .BASE_RST(1)) dut (
    .clock(clock), .reset(reset), .irq_src(irq_src),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_din(reg_din),
    .reg_dout(reg_dout), .cpu_intr(cpu_intr), .cpu_inta(cpu_inta),
    .cpu_inte(cpu_inte), .int_vec(int_vec)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    reg_sel = sel; reg_din = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] exp);
    rq.push_back(exp);
    reg_sel = sel; reg_rd = 1'b1;
    tick();
    reg_rd = 1'b0;
  endtask

  // Wait for intr, check the vector, run inta through ACK back to IDLE.
  task automatic serve(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (!cpu_intr && n < 30) begin tick(); n++; end
    vec_cnt++; if (cpu_intr !== 1'b1) begin err_cnt++; $display("FAIL %s_intr got=%b exp=1", tag, cpu_intr); end
    e = (vq.size() > 0) ? vq.pop_front() : 8'hxx;
    vec_cnt++; if (int_vec !== e) begin err_cnt++; $display("FAIL %s_vec got=%h exp=%h", tag, int_vec, e); end
    cpu_inta = 1'b1;
    tick();
    vec_cnt++; if (cpu_intr !== 1'b0 || int_vec !== e) begin err_cnt++; $display("FAIL %s_ack got=%b/%h exp=0/%h", tag, cpu_intr, int_vec, e); end
    cpu_inta = 1'b0;
    tick();
    vec_cnt++; if (int_vec !== 8'h00) begin err_cnt++; $display("FAIL %s_idle got=%h exp=00", tag, int_vec); end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    tick(3);
    vec_cnt++; if (cpu_intr !== 1'b0 || int_vec !== 8'h00) begin err_cnt++; $display("FAIL rst_out got=%b/%h exp=0/00", cpu_intr, int_vec); end
    reset = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), 8'h00);
      e = rq.pop_front();
      vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL rst_reg%0d got=%h exp=%h", s, reg_dout, e); end
    end
  endtask

  task automatic test_single();
    logic [7:0] e;
    wr(REG_MASK, 8'h01);
    irq_src = 4'b0001; vq.push_back(8'hCF);
    tick(2);
    vec_cnt++; if (cpu_intr !== 1'b0) begin err_cnt++; $display("FAIL single_early got=%b exp=0", cpu_intr); end
    tick();
    vec_cnt++; if (cpu_intr !== 1'b1) begin err_cnt++; $display("FAIL single_lat got=%b exp=1", cpu_intr); end
    irq_src = 4'b0000;
    rd(REG_STAT, 8'h80);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL single_busy got=%h exp=%h", reg_dout, e); end
    serve("single");
    rd(REG_PEND, 8'h00);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL single_pend got=%h exp=%h", reg_dout, e); end
    rd(REG_STAT, 8'h00);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL single_stat got=%h exp=%h", reg_dout, e); end
  endtask

  task automatic test_priority();
    logic [7:0] e;
    wr(REG_MASK, 8'h0F);
    irq_src = 4'b0110; vq.push_back(8'hD7); vq.push_back(8'hDF);
    serve("prio1");
    irq_src = 4'b0000;
    vec_cnt++; if (cpu_intr !== 1'b0) begin err_cnt++; $display("FAIL prio_gap got=%b exp=0", cpu_intr); end
    tick();
    vec_cnt++; if (cpu_intr !== 1'b1) begin err_cnt++; $display("FAIL prio_rereq got=%b exp=1", cpu_intr); end
    serve("prio2");
    rd(REG_STAT, 8'h02);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL prio_stat got=%h exp=%h", reg_dout, e); end
  endtask

  task automatic test_freeze();
    int n;
    irq_src = 4'b1000; vq.push_back(8'hE7); vq.push_back(8'hCF);
    n = 0;
    while (!cpu_intr && n < 30) begin tick(); n++; end
    vec_cnt++; if (cpu_intr !== 1'b1) begin err_cnt++; $display("FAIL frz_intr got=%b exp=1", cpu_intr); end
    irq_src = 4'b1001;
    tick(3);
    vec_cnt++; if (int_vec !== 8'hE7) begin err_cnt++; $display("FAIL frz_hold got=%h exp=e7", int_vec); end
    serve("frz3");
    serve("frz0");
    irq_src = 4'b0000;
  endtask

  task automatic test_mask_inte();
    logic [7:0] e;
    wr(REG_MASK, 8'h00);
    irq_src = 4'b0010; tick(4); irq_src = 4'b0000;
    vec_cnt++; if (cpu_intr !== 1'b0) begin err_cnt++; $display("FAIL mask_off got=%b exp=0", cpu_intr); end
    rd(REG_PEND, 8'h02);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL mask_pend got=%h exp=%h", reg_dout, e); end
    wr(REG_MASK, 8'h02);
    vec_cnt++; if (cpu_intr !== 1'b0) begin err_cnt++; $display("FAIL mask_wr got=%b exp=0", cpu_intr); end
    tick();
    vec_cnt++; if (cpu_intr !== 1'b1) begin err_cnt++; $display("FAIL mask_on got=%b exp=1", cpu_intr); end
    vq.push_back(8'hD7);
    serve("mask");
    cpu_inte = 1'b0;
    irq_src = 4'b0010; tick(4); irq_src = 4'b0000;
    vec_cnt++; if (cpu_intr !== 1'b0) begin err_cnt++; $display("FAIL inte_off got=%b exp=0", cpu_intr); end
    cpu_inte = 1'b1;
    tick();
    vec_cnt++; if (cpu_intr !== 1'b1) begin err_cnt++; $display("FAIL inte_on got=%b exp=1", cpu_intr); end
    vq.push_back(8'hD7);
    serve("inte");
  endtask

  task automatic test_w1c_race();
    logic [7:0] e;
    wr(REG_MASK, 8'h00);
    irq_src = 4'b0100;
    tick();
    wr(REG_PEND, 8'h04);  // lands on the edge that latches the src2 event
    rd(REG_PEND, 8'h04);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL w1c_race got=%h exp=%h", reg_dout, e); end
    wr(REG_PEND, 8'h04);
    rd(REG_PEND, 8'h00);
    e = rq.pop_front();
    vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL w1c_clr got=%h exp=%h", reg_dout, e); end
    irq_src = 4'b0000;
  endtask

  task automatic test_reset_ack();
    int n;
    logic [7:0] e;
    wr(REG_MASK, 8'h01);
    irq_src = 4'b0011; vq.push_back(8'hCF);
    n = 0;
    while (!cpu_intr && n < 30) begin tick(); n++; end
    e = (vq.size() > 0) ? vq.pop_front() : 8'hxx;
    vec_cnt++; if (int_vec !== e) begin err_cnt++; $display("FAIL rack_vec got=%h exp=%h", int_vec, e); end
    irq_src = 4'b0000;
    cpu_inta = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    vec_cnt++; if (cpu_intr !== 1'b0 || int_vec !== 8'h00) begin err_cnt++; $display("FAIL rack_out got=%b/%h exp=0/00", cpu_intr, int_vec); end
    reset = 1'b0; cpu_inta = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), 8'h00);
      e = rq.pop_front();
      vec_cnt++; if (reg_dout !== e) begin err_cnt++; $display("FAIL rack_reg%0d got=%h exp=%h", s, reg_dout, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_freeze();
    test_mask_inte();
    test_w1c_race();
    test_reset_ack();
    vec_cnt++; if (vq.size() != 0 || rq.size() != 0) begin err_cnt++; $display("FAIL sb_drain got=%0d/%0d exp=0/0", vq.size(), rq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/l80_intctrl.md
# l80_intctrl

Vectored interrupt controller for the light8080 SOC. Collects up to eight external or peripheral interrupt sources (UART rx/tx, port pins, timers), latches them as pending, and arbitrates by fixed priority. It drives the CPU `intr`/`inta` handshake and supplies a single-byte RST opcode on the CPU data-in mux while `inta` is high. Software sees a small mask/pending/status register window through the SOC I/O decode.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..8.
- BASE_RST, 1: RST number used for source 0; source i uses RST (BASE_RST+i); BASE_RST+NUM_SRC-1 must be ≤ 7.

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_src  in  NUM_SRC  raw interrupt requests; rising edge is the event (asynchronous-safe after sync stage).
- reg_sel  in  2  register select: 0 = MASK, 1 = PEND, 2 = STAT.
- reg_wr  in  1  one-cycle write strobe.
- reg_rd  in  1  one-cycle read strobe.
- reg_din  in  8  write data.
- reg_dout  out  8  read data, registered.
- cpu_intr  out  1  interrupt request to CPU.
- cpu_inta  in  1  CPU interrupt acknowledge.
- cpu_inte  in  1  CPU interrupt-enable flag.
- int_vec  out  8  RST opcode {2'b11, rst[2:0], 3'b111}; valid while state is REQ or ACK, else 8'h00.

## Operation
- Input stage: irq_s <= irq_src; irq_d <= irq_s; edge = irq_s & ~irq_d. Edge sets pending[i].
- MASK (RW): bit i = 1 enables source i. Bits ≥ NUM_SRC read 0, writes ignored.
- PEND (R, W1C): writing 1 clears pending[i]. An edge in the same cycle as a W1C on the same bit wins (bit stays set).
- STAT (R): bit7 = busy (state ≠ IDLE), bits2:0 = index of last acknowledged source.
- eligible = pending & MASK; winner = lowest set index (source 0 highest priority).
- FSM:
  - IDLE: if eligible ≠ 0 and cpu_inte = 1 → REQ; latch winner into win_idx.
  - REQ: cpu_intr = 1; int_vec from win_idx (frozen; later MASK/PEND writes or higher-priority edges do not change it). On cpu_inta = 1 → ACK: clear pending[win_idx], STAT[2:0] <= win_idx, cpu_intr <= 0. REQ is held independent of cpu_inte.
  - ACK: int_vec held; on cpu_inta = 0 → IDLE.
- Ack-clear and a new edge on the same bit in the same cycle: bit stays set.
- Reset: pending, MASK, win_idx, STAT, reg_dout = 0; state IDLE; cpu_intr = 0; int_vec = 8'h00; irq_s/irq_d = 0.
- Reset mid-handshake returns to IDLE immediately; cpu_intr drops the next cycle.

## Timing
- irq_src rise sampled at edge k → irq_s at k, pending at k+1, state REQ and cpu_intr = 1 at k+2 (if enabled and cpu_inte high).
- cpu_intr is a registered output; it deasserts the cycle after inta is first seen high.
- int_vec is combinational from state/win_idx, stable from REQ entry until ACK exit (whole inta window).
- reg_dout updated one cycle after reg_rd; holds value otherwise. Register writes take effect at the strobe edge.
- Minimum one IDLE cycle between consecutive interrupts (back-to-back return to REQ is not allowed).
- Level-held source produces exactly one event per rising edge.

## Structure
- Shared include file (l80soc_defs.vh): register select codes, RST opcode template 8'hC7, STAT bit positions; reused by the SOC I/O decode.
- One sub-module natural: l80_prio_enc (NUM_SRC-wide lowest-index priority encoder, valid + index out). Everything else is inline.
- SOC integration: int_vec is ORed into the CPU data-in mux when state ≠ IDLE.

## Test plan
- Single source: MASK = 8'h01, pulse irq_src[0] → cpu_intr high 2 cycles after sampling; on inta int_vec = 8'hCF (RST1); PEND reads 8'h00 after ack; STAT = 8'h00 after inta drops.
- Priority: MASK = 8'h0F, raise src2 and src1 same cycle → first vector 8'hD7 (RST2 for src1), after ack second vector 8'hDF (src2); at least one IDLE cycle between.
- Freeze: in REQ for src3 (8'hE7), raise src0 before inta → vector stays 8'hE7; src0 (8'hCF) delivered next.
- Masking/inte: pending src1 with MASK = 0 or cpu_inte = 0 → cpu_intr stays 0; setting MASK = 8'h02 with inte = 1 → cpu_intr within 1 cycle.
- W1C race: write PEND = 8'h04 in the same cycle as a src2 edge → PEND bit2 remains 1; W1C alone clears it.
- Reset in ACK: assert reset while inta high → cpu_intr = 0, int_vec = 8'h00, all registers read 0.
